// File: rtl/traffic_intersection_ctrl.sv
// rtl/traffic_intersection_ctrl.sv - two-road intersection sequencer with pedestrian phase
// Moore FSM: light enables and debug state code decode from the state register only.
module traffic_intersection_ctrl #(
  parameter int unsigned T_MIN_GRN  = 1000,
  parameter int unsigned T_YLW      = 300,
  parameter int unsigned T_ALLRED   = 100,
  parameter int unsigned T_SIDE_MIN = 500,
  parameter int unsigned T_SIDE_MAX = 2000,
  parameter int unsigned T_WALK     = 800
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       car_side,
  input  logic       ped_req,
  output logic       main_grn,
  output logic       main_ylw,
  output logic       main_red,
  output logic       side_grn,
  output logic       side_ylw,
  output logic       side_red,
  output logic       walk,
  output logic [2:0] state
);

  localparam int unsigned T_MAX_A = (T_MIN_GRN > T_YLW) ? T_MIN_GRN : T_YLW;
  localparam int unsigned T_MAX_B = (T_ALLRED > T_SIDE_MIN) ? T_ALLRED : T_SIDE_MIN;
  localparam int unsigned T_MAX_C = (T_SIDE_MAX > T_WALK) ? T_SIDE_MAX : T_WALK;
  localparam int unsigned T_MAX_D = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
  localparam int unsigned T_MAX   = (T_MAX_C > T_MAX_D) ? T_MAX_C : T_MAX_D;
  localparam int CW = $clog2(T_MAX) + 1;

  // Terminal counts: a state with duration T exits on the edge where cnt == T-1.
  localparam logic [CW-1:0] MIN_GRN_L  = CW'(T_MIN_GRN - 1);
  localparam logic [CW-1:0] YLW_L      = CW'(T_YLW - 1);
  localparam logic [CW-1:0] ALLRED_L   = CW'(T_ALLRED - 1);
  localparam logic [CW-1:0] SIDE_MIN_L = CW'(T_SIDE_MIN - 1);
  localparam logic [CW-1:0] SIDE_MAX_L = CW'(T_SIDE_MAX - 1);
  localparam logic [CW-1:0] WALK_L     = CW'(T_WALK - 1);

  typedef enum logic [2:0] {
    MAIN_G = 3'd0,
    MAIN_Y = 3'd1,
    CLR_A  = 3'd2,
    SIDE_G = 3'd3,
    SIDE_Y = 3'd4,
    CLR_B  = 3'd5,
    PED    = 3'd6
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt;
  logic            side_req_q, ped_req_q;
  logic            enter_side, enter_ped;

  always_comb begin
    state_d = state_q;
    case (state_q)
      MAIN_G: if (cnt >= MIN_GRN_L && (side_req_q || ped_req_q)) state_d = MAIN_Y;
      MAIN_Y: if (cnt == YLW_L) state_d = CLR_A;
      CLR_A:  if (cnt == ALLRED_L) state_d = ped_req_q ? PED : SIDE_G;
      SIDE_G: if (cnt == SIDE_MAX_L || (cnt >= SIDE_MIN_L && !car_side)) state_d = SIDE_Y;
      SIDE_Y: if (cnt == YLW_L) state_d = CLR_B;
      PED:    if (cnt == WALK_L) state_d = CLR_B;
      CLR_B:  if (cnt == ALLRED_L) state_d = MAIN_G;
      default: state_d = MAIN_G;
    endcase
  end

  assign enter_side = (state_d == SIDE_G) && (state_q != SIDE_G);
  assign enter_ped  = (state_d == PED) && (state_q != PED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= MAIN_G;
      cnt        <= '0;
      side_req_q <= 1'b0;
      ped_req_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q)
        cnt <= '0;
      else if (cnt != '1)
        cnt <= cnt + CW'(1);
      // Clear on phase entry beats a coincident set so the served request is consumed.
      if (enter_side)
        side_req_q <= 1'b0;
      else if (car_side && state_q != SIDE_G)
        side_req_q <= 1'b1;
      if (enter_ped)
        ped_req_q <= 1'b0;
      else if (ped_req && state_q != PED)
        ped_req_q <= 1'b1;
    end
  end

  always_comb begin
    main_grn = 1'b0;
    main_ylw = 1'b0;
    main_red = 1'b1;
    side_grn = 1'b0;
    side_ylw = 1'b0;
    side_red = 1'b1;
    walk     = 1'b0;
    case (state_q)
      MAIN_G: begin main_grn = 1'b1; main_red = 1'b0; end
      MAIN_Y: begin main_ylw = 1'b1; main_red = 1'b0; end
      SIDE_G: begin side_grn = 1'b1; side_red = 1'b0; end
      SIDE_Y: begin side_ylw = 1'b1; side_red = 1'b0; end
      PED:    walk = 1'b1;
      default: ;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
// tb/tb_traffic_intersection_ctrl.sv - directed bench for traffic_intersection_ctrl
module tb_traffic_intersection_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, car_side, ped_req;
  logic       main_grn, main_ylw, main_red, side_grn, side_ylw, side_red, walk;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  int         bc[12];
  logic [2:0] bs[12];
  int         nb;

  always #5 clk = ~clk;

  traffic_intersection_ctrl #(
    .T_MIN_GRN(10), .T_YLW(3), .T_ALLRED(2),
    .T_SIDE_MIN(5), .T_SIDE_MAX(20), .T_WALK(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .car_side(car_side), .ped_req(ped_req),
    .main_grn(main_grn), .main_ylw(main_ylw), .main_red(main_red),
    .side_grn(side_grn), .side_ylw(side_ylw), .side_red(side_red),
    .walk(walk), .state(state)
  );

  wire [9:0] act_vec = {state, main_grn, main_ylw, main_red, side_grn, side_ylw, side_red, walk};

  function automatic logic [9:0] exp_vec(input logic [2:0] s);
    case (s)
      3'd0:    return {3'd0, 7'b100_001_0};
      3'd1:    return {3'd1, 7'b010_001_0};
      3'd2:    return {3'd2, 7'b001_001_0};
      3'd3:    return {3'd3, 7'b001_100_0};
      3'd4:    return {3'd4, 7'b001_010_0};
      3'd5:    return {3'd5, 7'b001_001_0};
      default: return {3'd6, 7'b001_001_1};
    endcase
  endfunction

  function automatic logic [2:0] exp_state(input int c);
    logic [2:0] s;
    s = bs[0];
    for (int i = 0; i < nb; i++)
      if (bc[i] <= c) s = bs[i];
    return s;
  endfunction

  // Per-road one-hot and WALK-only-in-all-red, every cycle out of reset.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      checks++;
      if ($countones({main_grn, main_ylw, main_red}) != 1 ||
          $countones({side_grn, side_ylw, side_red}) != 1 ||
          (walk && !(main_red && side_red))) begin
        errors++;
        $display("FAIL invariant t=%0t: got lights=%b required one-hot per road, walk only in all-red",
                 $time, act_vec[6:0]);
      end
    end
  end

  task automatic reset_dut();
    car_side = 1'b0;
    ped_req  = 1'b0;
    rst_n    = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    car_side = 1'b0;
    ped_req  = 1'b0;
    rst_n    = 1'b0;
    #3;
    checks++;
    if (act_vec !== exp_vec(3'd0)) begin
      errors++;
      $display("FAIL reset_hold: got %b required %b", act_vec, exp_vec(3'd0));
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    bc = '{0, 102, 105, 107, 115, 117, 0, 0, 0, 0, 0, 0};
    bs = '{3'd0, 3'd1, 3'd2, 3'd6, 3'd5, 3'd0, 0, 0, 0, 0, 0, 0};
    nb = 6;
    for (int c = 0; c <= 120; c++) begin
      ped_req = (c == 100);
      @(negedge clk);
      checks++;
      if (act_vec !== exp_vec(exp_state(c))) begin
        errors++;
        $display("FAIL idle_then_ped cycle %0d: got %b required %b", c, act_vec, exp_vec(exp_state(c)));
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_side_pulse();
    reset_dut();
    bc = '{0, 10, 13, 15, 20, 23, 25, 0, 0, 0, 0, 0};
    bs = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 0, 0, 0, 0, 0};
    nb = 7;
    for (int c = 0; c <= 40; c++) begin
      car_side = (c == 2);
      @(negedge clk);
      checks++;
      if (act_vec !== exp_vec(exp_state(c))) begin
        errors++;
        $display("FAIL side_pulse cycle %0d: got %b required %b", c, act_vec, exp_vec(exp_state(c)));
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_side_max();
    reset_dut();
    bc = '{0, 10, 13, 15, 35, 38, 40, 50, 53, 55, 0, 0};
    bs = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd3, 0, 0};
    nb = 10;
    for (int c = 0; c <= 60; c++) begin
      car_side = (c >= 2);
      @(negedge clk);
      checks++;
      if (act_vec !== exp_vec(exp_state(c))) begin
        errors++;
        $display("FAIL side_max cycle %0d: got %b required %b", c, act_vec, exp_vec(exp_state(c)));
      end
      @(posedge clk);
      #1;
    end
    car_side = 1'b0;
  endtask

  task automatic test_ped_priority();
    reset_dut();
    bc = '{0, 10, 13, 15, 23, 25, 35, 38, 40, 45, 48, 50};
    bs = '{3'd0, 3'd1, 3'd2, 3'd6, 3'd5, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0};
    nb = 12;
    for (int c = 0; c <= 55; c++) begin
      car_side = (c == 3);
      ped_req  = (c == 3);
      @(negedge clk);
      checks++;
      if (act_vec !== exp_vec(exp_state(c))) begin
        errors++;
        $display("FAIL ped_priority cycle %0d: got %b required %b", c, act_vec, exp_vec(exp_state(c)));
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_ped_during_side();
    reset_dut();
    bc = '{0, 10, 13, 15, 20, 23, 25, 35, 38, 40, 48, 50};
    bs = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd6, 3'd5, 3'd0};
    nb = 12;
    for (int c = 0; c <= 55; c++) begin
      car_side = (c == 2);
      ped_req  = (c == 16);
      @(negedge clk);
      checks++;
      if (act_vec !== exp_vec(exp_state(c))) begin
        errors++;
        $display("FAIL ped_during_side cycle %0d: got %b required %b", c, act_vec, exp_vec(exp_state(c)));
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset_mid_yellow();
    reset_dut();
    bc = '{0, 10, 13, 15, 20, 0, 0, 0, 0, 0, 0, 0};
    bs = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 0, 0, 0, 0, 0, 0, 0};
    nb = 5;
    for (int c = 0; c <= 20; c++) begin
      car_side = (c == 2) || (c == 20);
      @(negedge clk);
      checks++;
      if (act_vec !== exp_vec(exp_state(c))) begin
        errors++;
        $display("FAIL reset_mid_pre cycle %0d: got %b required %b", c, act_vec, exp_vec(exp_state(c)));
      end
      @(posedge clk);
      #1;
    end
    car_side = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (act_vec !== exp_vec(3'd0)) begin
      errors++;
      $display("FAIL reset_async: got %b required %b", act_vec, exp_vec(3'd0));
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c <= 40; c++) begin
      @(negedge clk);
      checks++;
      if (act_vec !== exp_vec(3'd0)) begin
        errors++;
        $display("FAIL reset_no_resume cycle %0d: got %b required %b", c, act_vec, exp_vec(3'd0));
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    test_reset();
    test_side_pulse();
    test_side_max();
    test_ped_priority();
    test_ped_during_side();
    test_reset_mid_yellow();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
